// File: rtl/hex_entry_bank.sv
// Multi-channel hex word editor: buttons move a digit cursor and step, clear or
// auto-repeat edits on the selected channel.
//
//   state  | meaning
//   IDLE   | no qualifying button held
//   WAIT   | button held, counting toward auto-repeat
//   REPEAT | auto-repeat active, one action every RATE cycles
module hex_entry_bank #(
  parameter int          DIGITS   = 8,
  parameter int          CHANNELS = 4,
  parameter int          CARRY    = 0,
  parameter logic [63:0] INIT     = 64'h0000_0000_8765_4321,
  parameter int          HOLD     = 50_000_000,
  parameter int          RATE     = 10_000_000,
  localparam int         W        = 4 * DIGITS,
  localparam int         SW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int         CW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            BTN,
  input  logic                  en,
  input  logic [SW-1:0]         sel,
  output logic [CHANNELS*W-1:0] values,
  output logic [W-1:0]          cur_val,
  output logic [DIGITS-1:0]     blink,
  output logic [CW-1:0]         cursor
);

  localparam int             CMAX    = (HOLD > RATE) ? HOLD : RATE;
  localparam int             CNTW    = $clog2(CMAX + 1);
  // WAIT is entered with the press action, so the second action lands HOLD-1 edges later
  localparam logic [CNTW-1:0] HOLD_TC = CNTW'(HOLD - 2);
  localparam logic [CNTW-1:0] RATE_TC = CNTW'(RATE - 1);
  localparam logic [W-1:0]    INIT_W  = W'(INIT);
  localparam logic [CW-1:0]   CUR_TOP = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, REPEAT} state_t;
  typedef enum logic [2:0] {B_NONE, B_LEFT, B_RIGHT, B_INC, B_DEC, B_CLR} btn_t;

  state_t          state, state_nx;
  btn_t            active, held, held_nx;
  logic [CNTW-1:0] cnt, cnt_nx;
  logic            pulse;

  logic [W-1:0]    chan [CHANNELS];
  logic [CW-1:0]   cur, cur_nx;
  logic            sel_ok;
  logic [W-1:0]    sel_word, step, inc_word, dec_word, new_word;
  logic            wr;

  always_comb begin
    active = B_NONE;
    if (BTN[4])      active = B_LEFT;
    else if (BTN[2]) active = B_RIGHT;
    else if (BTN[3]) active = B_INC;
    else if (BTN[1]) active = B_DEC;
    else if (BTN[0]) active = B_CLR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      held  <= B_NONE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      held  <= held_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    held_nx  = held;
    cnt_nx   = cnt;
    pulse    = 1'b0;
    if (!en || active == B_NONE) begin
      state_nx = IDLE;
      held_nx  = B_NONE;
      cnt_nx   = '0;
    end else if (state == IDLE || active != held) begin
      state_nx = WAIT;
      held_nx  = active;
      cnt_nx   = '0;
      pulse    = 1'b1;
    end else if (state == WAIT) begin
      if (cnt == HOLD_TC) begin
        state_nx = REPEAT;
        cnt_nx   = '0;
        pulse    = 1'b1;
      end else begin
        cnt_nx = cnt + CNTW'(1);
      end
    end else begin
      if (cnt == RATE_TC) begin
        cnt_nx = '0;
        pulse  = 1'b1;
      end else begin
        cnt_nx = cnt + CNTW'(1);
      end
    end
  end

  always_comb begin
    sel_ok   = 1'b0;
    sel_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SW'(k)) begin
        sel_ok   = 1'b1;
        sel_word = chan[k];
      end
    end
  end

  always_comb begin
    step     = W'(1) << {cur, 2'b00};
    inc_word = sel_word;
    dec_word = sel_word;
    if (CARRY != 0) begin
      inc_word = sel_word + step;
      dec_word = sel_word - step;
    end else begin
      for (int d = 0; d < DIGITS; d++) begin
        if (cur == CW'(d)) begin
          inc_word[d*4 +: 4] = sel_word[d*4 +: 4] + 4'd1;
          dec_word[d*4 +: 4] = sel_word[d*4 +: 4] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    wr       = 1'b0;
    new_word = sel_word;
    cur_nx   = cur;
    if (pulse) begin
      case (active)
        B_LEFT:  cur_nx = (cur == CUR_TOP) ? '0 : cur + CW'(1);
        B_RIGHT: cur_nx = (cur == '0) ? CUR_TOP : cur - CW'(1);
        B_INC: begin
          wr       = sel_ok;
          new_word = inc_word;
        end
        B_DEC: begin
          wr       = sel_ok;
          new_word = dec_word;
        end
        B_CLR: begin
          wr       = sel_ok;
          new_word = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) chan[k] <= INIT_W;
      cur <= CUR_TOP;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (wr && sel == SW'(k)) chan[k] <= new_word;
      end
      cur <= cur_nx;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_values
    assign values[k*W +: W] = chan[k];
  end

  assign cur_val = sel_word;
  assign cursor  = cur;
  assign blink   = en ? (DIGITS'(1) << cur) : '0;

endmodule

// File: tb/tb_hex_entry_bank.sv
// Bench for hex_entry_bank: a wrapping-nibble and a carrying instance share
// stimulus and are checked each cycle against a press-count model.
module tb_hex_entry_bank;

  localparam int HOLD_T = 4;
  localparam int RATE_T = 2;
  localparam int NCH    = 5;
  localparam logic [4:0] LEFT = 5'b10000, RIGHT = 5'b00100, INC = 5'b01000,
                         DEC = 5'b00010, CLR = 5'b00001;

  logic         clk, rst_n, en;
  logic [4:0]   btn;
  logic [2:0]   sel;
  logic [159:0] values_a, values_b;
  logic [31:0]  cur_val_a, cur_val_b;
  logic [7:0]   blink_a, blink_b;
  logic [2:0]   cursor_a, cursor_b;

  hex_entry_bank #(.DIGITS(8), .CHANNELS(NCH), .CARRY(0), .HOLD(HOLD_T), .RATE(RATE_T)) dut_a (
    .clk(clk), .rst_n(rst_n), .BTN(btn), .en(en), .sel(sel),
    .values(values_a), .cur_val(cur_val_a), .blink(blink_a), .cursor(cursor_a));

  hex_entry_bank #(.DIGITS(8), .CHANNELS(NCH), .CARRY(1), .HOLD(HOLD_T), .RATE(RATE_T)) dut_b (
    .clk(clk), .rst_n(rst_n), .BTN(btn), .en(en), .sel(sel),
    .values(values_b), .cur_val(cur_val_b), .blink(blink_b), .cursor(cursor_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit running = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- model: actions fall on press sample 1, HOLD, HOLD+RATE, HOLD+2*RATE, ...
  logic [31:0] mval_a [NCH];
  logic [31:0] mval_b [NCH];
  int mcur, press_n, prev_b, n_actions, m_b;

  function automatic int prio(input logic [4:0] b);
    if (b[4]) return 4;
    if (b[2]) return 2;
    if (b[3]) return 3;
    if (b[1]) return 1;
    if (b[0]) return 0;
    return -1;
  endfunction

  function automatic logic [31:0] nib_step(input logic [31:0] v, input int c, input int d);
    int n;
    n = int'((v >> (4 * c)) & 32'hF);
    n = (n + d + 16) % 16;
    return (v & ~(32'hF << (4 * c))) | (32'(n) << (4 * c));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      mval_a[k] = 32'h87654321;
      mval_b[k] = 32'h87654321;
    end
    mcur    = 7;
    press_n = 0;
    prev_b  = -1;
  endtask

  initial begin
    n_actions = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        m_b = prio(btn);
        if (!en || m_b < 0) begin
          press_n = 0;
          prev_b  = -1;
        end else if (m_b != prev_b) begin
          press_n = 1;
          prev_b  = m_b;
        end else begin
          press_n++;
        end
        if (press_n == 1 || press_n == HOLD_T ||
            (press_n > HOLD_T && (press_n - HOLD_T) % RATE_T == 0)) begin
          n_actions++;
          case (m_b)
            4: mcur = (mcur + 1) % 8;
            2: mcur = (mcur + 7) % 8;
            3, 1: if (sel < NCH) begin
              mval_a[sel] = nib_step(mval_a[sel], mcur, (m_b == 3) ? 1 : -1);
              if (m_b == 3) mval_b[sel] = mval_b[sel] + (32'd1 << (4 * mcur));
              else          mval_b[sel] = mval_b[sel] - (32'd1 << (4 * mcur));
            end
            0: if (sel < NCH) begin
              mval_a[sel] = 32'd0;
              mval_b[sel] = 32'd0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---- per-cycle compare
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        for (int k = 0; k < NCH; k++) begin
          chk("values_a", values_a[k*32 +: 32], mval_a[k]);
          chk("values_b", values_b[k*32 +: 32], mval_b[k]);
        end
        if (sel < NCH) begin
          chk("cur_val_a", cur_val_a, mval_a[sel]);
          chk("cur_val_b", cur_val_b, mval_b[sel]);
        end else begin
          chk("cur_val_a_oob", cur_val_a, 32'd0);
          chk("cur_val_b_oob", cur_val_b, 32'd0);
        end
        chk("cursor_a", 32'(cursor_a), 32'(mcur));
        chk("cursor_b", 32'(cursor_b), 32'(mcur));
        chk("blink_a", 32'(blink_a), en ? (32'd1 << mcur) : 32'd0);
        chk("blink_b", 32'(blink_b), en ? (32'd1 << mcur) : 32'd0);
      end
    end
  end

  task automatic press(input logic [4:0] b, input int n);
    btn = b;
    repeat (n) @(negedge clk);
    btn = 5'b0;
    @(negedge clk);
  endtask

  int na;

  initial begin
    rst_n = 1'b1; en = 1'b0; btn = 5'b0; sel = 3'd0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ch0", values_a[31:0], 32'h87654321);
    chk("rst_ch4_b", values_b[159:128], 32'h87654321);
    chk("rst_cursor", 32'(cursor_a), 32'd7);
    chk("rst_blink_off", 32'(blink_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    #1 chk("blink_top", 32'(blink_a), 32'h80);

    press(LEFT, 1);
    chk("left_wrap_cursor", 32'(cursor_a), 32'd0);
    chk("left_wrap_blink", 32'(blink_a), 32'h01);

    na = n_actions;
    press(INC, 1);
    chk("inc_once", values_a[31:0], 32'h87654322);
    chk("inc_one_action", 32'(n_actions - na), 32'd1);

    press(LEFT | INC, 1);
    chk("left_prio_cursor", 32'(cursor_a), 32'd1);
    chk("left_prio_value", values_a[31:0], 32'h87654322);
    press(RIGHT, 1);
    chk("right_cursor", 32'(cursor_a), 32'd0);

    sel = 3'd1;
    press(CLR, 1);
    chk("clr_ch1", values_b[63:32], 32'd0);
    press(DEC, 1);
    chk("carry_borrow", values_b[63:32], 32'hFFFFFFFF);
    chk("nib_borrow", values_a[63:32], 32'h0000000F);
    repeat (4) press(LEFT, 1);
    press(INC, 1);
    chk("carry_out_drop", values_b[63:32], 32'h0000FFFF);
    chk("nib_inc4", values_a[63:32], 32'h0001000F);
    repeat (4) press(RIGHT, 1);
    press(INC, 1);
    chk("carry_ripple", values_b[63:32], 32'h00010000);
    chk("nib_wrap", values_a[63:32], 32'h00010000);

    sel = 3'd0;
    na = n_actions;
    press(INC, 10);
    chk("repeat_value", values_a[31:0], 32'h87654327);
    chk("repeat_actions", 32'(n_actions - na), 32'd5);
    repeat (5) @(negedge clk);
    chk("release_actions", 32'(n_actions - na), 32'd5);
    chk("release_value", values_b[31:0], 32'h87654327);

    sel = 3'd5;
    press(DEC, 1);
    chk("oob_cur_val", cur_val_a, 32'd0);
    chk("oob_ch0", values_a[31:0], 32'h87654327);
    press(LEFT, 1);
    chk("oob_cursor", 32'(cursor_a), 32'd1);
    press(RIGHT, 1);
    sel = 3'd2;
    press(CLR, 1);
    chk("clr_ch2", values_a[95:64], 32'd0);
    chk("clr_keep_ch3", values_a[127:96], 32'h87654321);

    sel = 3'd0;
    btn = INC;
    repeat (3) @(negedge clk);
    sel = 3'd3;
    repeat (4) @(negedge clk);
    btn = 5'b0;
    @(negedge clk);

    btn = DEC;
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("en_off_blink", 32'(blink_a), 32'd0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    btn = 5'b0;
    @(negedge clk);

    btn = INC;
    repeat (5) @(negedge clk);
    btn = DEC;
    repeat (2) @(negedge clk);
    btn = 5'b0;
    @(negedge clk);

    sel = 3'd0;
    btn = INC;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ch0", values_a[31:0], 32'h87654321);
    chk("midrst_cursor", 32'(cursor_a), 32'd7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release_no_action", values_a[31:0], 32'h87654321);
    @(negedge clk);
    chk("held_through_reset", values_a[31:0], 32'h97654321);
    chk("held_through_reset_b", values_b[31:0], 32'h97654321);
    btn = 5'b0;
    repeat (2) @(negedge clk);

    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
